// File: rtl/rc4_key_search_ctrl_if.sv
// Handshake and status bundle between the RC4 key-search controller and its
// environment (command source plus RC4 core).
interface rc4_key_search_ctrl_if;
   logic       start;
   logic       stop;
   logic [7:0] secret_key [3];
   logic       core_start;
   logic       core_abort;
   logic       core_byte_valid;
   logic [7:0] core_byte;
   logic       core_done;
   logic       busy;
   logic       key_found;
   logic       key_fail;
   logic [23:0] found_key;
   logic       protocol_err;

   modport master (
      input  start, stop, core_byte_valid, core_byte, core_done,
      output secret_key, core_start, core_abort, busy, key_found, key_fail,
             found_key, protocol_err
   );

   modport slave (
      output start, stop, core_byte_valid, core_byte, core_done,
      input  secret_key, core_start, core_abort, busy, key_found, key_fail,
             found_key, protocol_err
   );
endinterface

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key search: launches the core once per key and accepts the
// first key whose decrypted message is entirely lowercase letters and spaces.
module rc4_key_search_ctrl #(
   parameter int unsigned KEY_BITS = 22,
   parameter int unsigned MSG_LEN  = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   rc4_key_search_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, LAUNCH, RUN, ABORT, NEXT, FOUND, FAIL} state_t;

   state_t              state_q, state_d;
   logic [KEY_BITS-1:0] key_q, key_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                found_q, found_d;
   logic                fail_q, fail_d;
   logic                perr_q, perr_d;
   logic                stop_abort_q, stop_abort_d;
   logic [23:0]         found_key_q, found_key_d;

   logic [23:0] key_ext;
   logic        busy_w;
   logic        byte_ok;
   logic        bad_byte;
   logic [7:0]  cnt_now;

   assign key_ext  = 24'(key_q);
   assign busy_w   = (state_q == LAUNCH) || (state_q == RUN) ||
                     (state_q == ABORT)  || (state_q == NEXT);
   assign byte_ok  = ((bus.core_byte >= 8'd97) && (bus.core_byte <= 8'd122)) ||
                     (bus.core_byte == 8'd32);
   assign bad_byte = bus.core_byte_valid && !byte_ok;
   // A byte arriving together with core_done is counted before the length check.
   assign cnt_now  = bus.core_byte_valid ? (cnt_q + 8'd1) : cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         key_q        <= '0;
         cnt_q        <= '0;
         found_q      <= 1'b0;
         fail_q       <= 1'b0;
         perr_q       <= 1'b0;
         stop_abort_q <= 1'b0;
         found_key_q  <= '0;
      end else begin
         state_q      <= state_d;
         key_q        <= key_d;
         cnt_q        <= cnt_d;
         found_q      <= found_d;
         fail_q       <= fail_d;
         perr_q       <= perr_d;
         stop_abort_q <= stop_abort_d;
         found_key_q  <= found_key_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      key_d        = key_q;
      cnt_d        = cnt_q;
      found_d      = found_q;
      fail_d       = fail_q;
      perr_d       = perr_q;
      found_key_d  = found_key_q;
      stop_abort_d = 1'b0;

      case (state_q)
         IDLE, FOUND, FAIL: begin
            if (bus.start) begin
               key_d       = '0;
               cnt_d       = '0;
               found_d     = 1'b0;
               fail_d      = 1'b0;
               perr_d      = 1'b0;
               found_key_d = '0;
               state_d     = LAUNCH;
            end
         end
         LAUNCH: begin
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            cnt_d = cnt_now;
            if (bad_byte) begin
               state_d = ABORT;
            end else if (bus.core_done) begin
               if (cnt_now == 8'(MSG_LEN)) begin
                  found_d     = 1'b1;
                  found_key_d = key_ext;
                  state_d     = FOUND;
               end else begin
                  perr_d  = 1'b1;
                  state_d = NEXT;
               end
            end
         end
         ABORT: state_d = NEXT;
         NEXT: begin
            if (key_q == '1) begin
               fail_d  = 1'b1;
               state_d = FAIL;
            end else begin
               key_d   = key_q + 1'b1;
               state_d = LAUNCH;
            end
         end
         default: state_d = IDLE;
      endcase

      // Cancel discards every other same-cycle update; ABORT already drives the pulse.
      if (bus.stop && busy_w) begin
         state_d      = IDLE;
         key_d        = key_q;
         cnt_d        = cnt_q;
         found_d      = found_q;
         fail_d       = fail_q;
         perr_d       = perr_q;
         found_key_d  = found_key_q;
         stop_abort_d = (state_q != ABORT);
      end
   end

   assign bus.secret_key[0] = key_ext[23:16];
   assign bus.secret_key[1] = key_ext[15:8];
   assign bus.secret_key[2] = key_ext[7:0];
   assign bus.core_start    = (state_q == LAUNCH);
   assign bus.core_abort    = (state_q == ABORT) || stop_abort_q;
   assign bus.busy          = busy_w;
   assign bus.key_found     = found_q;
   assign bus.key_fail      = fail_q;
   assign bus.found_key     = found_key_q;
   assign bus.protocol_err  = perr_q;
endmodule

// File: doc/rc4_key_search_ctrl.md
RC4_KEY_SEARCH_CTRL -- requirements
Module: rc4_key_search_ctrl

Interface
REQ-001 The block SHALL have parameters:
- KEY_BITS, 22, number of searched low key bits (upper 24-KEY_BITS key bits forced 0).
- MSG_LEN, 32, decrypted message length in bytes.
REQ-002 The block SHALL have ports:
- clk  in  1  sole clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse, begin search from key 0.
- stop  in  1  one-cycle pulse, cancel search.
- secret_key  out  8x3  unpacked key bytes to RC4 core; [0]=key[23:16], [1]=key[15:8], [2]=key[7:0].
- core_start  out  1  one-cycle launch pulse to RC4 core (init+shuffle+decrypt).
- core_abort  out  1  one-cycle pulse, core returns to idle next cycle.
- core_byte_valid  in  1  decrypted byte strobe.
- core_byte  in  8  decrypted byte.
- core_done  in  1  core finished MSG_LEN bytes.
- busy  out  1  search in progress.
- key_found  out  1  sticky, search succeeded.
- key_fail  out  1  sticky, key space exhausted.
- found_key  out  24  winning key, valid while key_found=1.
- protocol_err  out  1  sticky, core_done seen with byte count != MSG_LEN.

Function
REQ-003 States SHALL be IDLE, LAUNCH, RUN, ABORT, NEXT, FOUND, FAIL.
REQ-004 IDLE: busy=0; start -> clear key counter, byte counter, key_found, key_fail, protocol_err; go LAUNCH.
REQ-005 LAUNCH: core_start=1 for exactly this cycle; byte counter cleared; go RUN.
REQ-006 secret_key SHALL equal {zeros, key counter} and stay stable from LAUNCH through exit of RUN/ABORT.
REQ-007 RUN: each core_byte_valid increments 8-bit byte counter; byte valid iff 8'd97..8'd122 or 8'd32.
REQ-008 RUN, invalid byte -> ABORT next cycle; no further bytes evaluated for that key.
REQ-009 RUN, core_done with counter==MSG_LEN and all bytes valid -> FOUND.
REQ-010 RUN, core_done with counter!=MSG_LEN -> set protocol_err, go NEXT (key treated as failed).
REQ-011 core_byte_valid and core_done same cycle: byte counted and checked first; invalid byte wins (ABORT).
REQ-012 ABORT: core_abort=1 for exactly this cycle; go NEXT.
REQ-013 NEXT: key counter == 2^KEY_BITS-1 -> FAIL; else key+1, go LAUNCH (2 cycles from fail detection to next core_start).
REQ-014 FOUND: key_found=1, found_key=current key, busy=0; hold until start.
REQ-015 FAIL: key_fail=1, busy=0; hold until start.
REQ-016 start in FOUND/FAIL SHALL restart as from IDLE; start while busy SHALL be ignored.
REQ-017 stop in LAUNCH/RUN/ABORT/NEXT SHALL assert core_abort one cycle (unless already asserted) and go IDLE; stop overrides all same-cycle transitions; key_found/key_fail unchanged.
REQ-018 busy=1 in LAUNCH, RUN, ABORT, NEXT only.
REQ-019 core_start and core_abort SHALL never be high in the same cycle.
REQ-020 Key counter SHALL be KEY_BITS wide and never wrap past 2^KEY_BITS-1.

Reset
REQ-021 reset=1 SHALL immediately force IDLE, all outputs 0, key and byte counters 0, regardless of state.
REQ-022 reset mid-RUN SHALL NOT pulse core_abort; core reset is the system's responsibility.

Verification
REQ-023 Core model returns 32 bytes "abc..." for key 0 -> core_start once, key_found=1, found_key=0, busy=0.
REQ-024 Keys 0..2 give first byte 0x41, key 3 valid -> 3 core_abort pulses, 4 core_start pulses, found_key=24'd3.
REQ-025 KEY_BITS=2, all keys invalid -> 4 launches, key_fail=1, key_found=0, secret_key[2]=8'd3 at end.
REQ-026 core_done after 31 valid bytes at key 0, key 1 valid -> protocol_err=1, found_key=1.
REQ-027 stop during RUN at key 5 -> core_abort pulse next edge, IDLE, busy=0, no further core_start.
REQ-028 reset asserted mid-RUN -> all outputs 0 without waiting for clk; start afterward relaunches at key 0.
